// File: rtl/mem_port_arbiter.sv
// Arbitrates Memory port a between the CPU load/store stage and the loader, with loader lock.
// Define MEM_ARB_STARVE_GUARD_EN to add the loader anti-starvation counter (otherwise strict CPU priority).
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_data,
    input  logic [2:0]  cpu_writeMode,
    input  logic [2:0]  cpu_readMode,
    input  logic        cpu_unsignedLoad,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        ldr_req,
    input  logic [31:0] ldr_address,
    input  logic [31:0] ldr_data,
    input  logic [2:0]  ldr_writeMode,
    input  logic [2:0]  ldr_readMode,
    input  logic        ldr_unsignedLoad,
    input  logic        ldr_lock,
    output logic        ldr_gnt,
    output logic        ldr_rvalid,
    output logic [31:0] ldr_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic [2:0]  mem_writeMode,
    output logic [2:0]  mem_readMode,
    output logic        mem_unsignedLoad,
    input  logic [31:0] mem_dataOutput,
    output logic        locked
);
    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t      state_q, state_d;
    logic        rd_pending_q, rd_owner_q;
    logic        rd_issue;
    logic        force_ldr;
    logic [31:0] cpu_rdata_q, ldr_rdata_q;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);
    logic [3:0] starve_q, starve_d;

    assign force_ldr = ldr_req && (starve_q == LIMIT_C);

    // Saturating count of consecutive cycles the loader asked and lost.
    always_comb begin
        starve_d = 4'd0;
        if (ldr_req && !ldr_gnt)
            starve_d = (starve_q == LIMIT_C) ? starve_q : starve_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) starve_q <= 4'd0;
        else      starve_q <= starve_d;
    end
`else
    assign force_ldr = 1'b0;
`endif

    always_comb begin
        cpu_gnt = 1'b0;
        ldr_gnt = 1'b0;
        if (state_q == S_LOCKED) begin
            ldr_gnt = ldr_req;
        end else begin
            ldr_gnt = ldr_req && (force_ldr || !cpu_req);
            cpu_gnt = cpu_req && !force_ldr;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (ldr_gnt && ldr_lock) state_d = S_LOCKED;
        end else if (!ldr_lock) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        mem_address      = 32'd0;
        mem_data         = 32'd0;
        mem_writeMode    = 3'd0;
        mem_readMode     = 3'd0;
        mem_unsignedLoad = 1'b0;
        if (ldr_gnt) begin
            mem_address      = ldr_address;
            mem_data         = ldr_data;
            mem_writeMode    = ldr_writeMode;
            mem_readMode     = ldr_readMode;
            mem_unsignedLoad = ldr_unsignedLoad;
        end else if (cpu_gnt) begin
            mem_address      = cpu_address;
            mem_data         = cpu_data;
            mem_writeMode    = cpu_writeMode;
            mem_readMode     = cpu_readMode;
            mem_unsignedLoad = cpu_unsignedLoad;
        end
    end

    // A write mode takes precedence in Memory, so only pure reads return data.
    assign rd_issue = (cpu_gnt || ldr_gnt) && (mem_readMode != 3'd0) && (mem_writeMode == 3'd0);

    // Read data is taken straight from Memory in its valid cycle; outputs are forced quiet in reset.
    assign cpu_rvalid = rst && rd_pending_q && !rd_owner_q;
    assign ldr_rvalid = rst && rd_pending_q && rd_owner_q;
    assign cpu_rdata  = !rst ? 32'd0 : (cpu_rvalid ? mem_dataOutput : cpu_rdata_q);
    assign ldr_rdata  = !rst ? 32'd0 : (ldr_rvalid ? mem_dataOutput : ldr_rdata_q);
    assign locked     = rst && (state_q == S_LOCKED);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            cpu_rdata_q  <= 32'd0;
            ldr_rdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= rd_issue;
            rd_owner_q   <= ldr_gnt;
            cpu_rdata_q  <= cpu_rdata;
            ldr_rdata_q  <= ldr_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected read data queued at grant, compared at rvalid.
// Expectations for the starvation case follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_unsignedLoad, cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_address, cpu_data, cpu_rdata;
    logic [2:0]  cpu_writeMode, cpu_readMode;
    logic        ldr_req, ldr_unsignedLoad, ldr_lock, ldr_gnt, ldr_rvalid;
    logic [31:0] ldr_address, ldr_data, ldr_rdata;
    logic [2:0]  ldr_writeMode, ldr_readMode;
    logic [31:0] mem_address, mem_data, mem_dataOutput;
    logic [2:0]  mem_writeMode, mem_readMode;
    logic        mem_unsignedLoad, locked;

    typedef struct {
        bit          owner;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_cpu = 32'd0;
    logic [31:0] last_ldr = 32'd0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_data(cpu_data),
        .cpu_writeMode(cpu_writeMode), .cpu_readMode(cpu_readMode),
        .cpu_unsignedLoad(cpu_unsignedLoad), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_address(ldr_address), .ldr_data(ldr_data),
        .ldr_writeMode(ldr_writeMode), .ldr_readMode(ldr_readMode),
        .ldr_unsignedLoad(ldr_unsignedLoad), .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt),
        .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_writeMode(mem_writeMode), .mem_readMode(mem_readMode),
        .mem_unsignedLoad(mem_unsignedLoad), .mem_dataOutput(mem_dataOutput),
        .locked(locked)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_cpu(input bit req, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] wr, input logic [2:0] rd, input bit u);
        cpu_req = req; cpu_address = a; cpu_data = d;
        cpu_writeMode = wr; cpu_readMode = rd; cpu_unsignedLoad = u;
    endtask

    task automatic set_ldr(input bit req, input bit lk, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] wr, input logic [2:0] rd, input bit u);
        ldr_req = req; ldr_lock = lk; ldr_address = a; ldr_data = d;
        ldr_writeMode = wr; ldr_readMode = rd; ldr_unsignedLoad = u;
    endtask

    // One clock of traffic: settle, score rvalid, check grant/port, queue any read, drive return data.
    task automatic step(input string tag, input bit e_cg, input bit e_lg, input bit e_lk,
                        input logic [31:0] rdat);
        exp_t        e;
        logic [31:0] ea, ed;
        logic [6:0]  ec;
        bit          is_rd;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.owner) begin
                check_val({tag, "/ldr_rvalid"}, ldr_rvalid, 1);
                check_val({tag, "/cpu_rvalid"}, cpu_rvalid, 0);
                check_val({tag, "/ldr_rdata"}, ldr_rdata, e.data);
                check_val({tag, "/cpu_rdata_hold"}, cpu_rdata, last_cpu);
                last_ldr = e.data;
            end else begin
                check_val({tag, "/cpu_rvalid"}, cpu_rvalid, 1);
                check_val({tag, "/ldr_rvalid"}, ldr_rvalid, 0);
                check_val({tag, "/cpu_rdata"}, cpu_rdata, e.data);
                check_val({tag, "/ldr_rdata_hold"}, ldr_rdata, last_ldr);
                last_cpu = e.data;
            end
        end else begin
            check_val({tag, "/cpu_rvalid"}, cpu_rvalid, 0);
            check_val({tag, "/ldr_rvalid"}, ldr_rvalid, 0);
            check_val({tag, "/cpu_rdata_hold"}, cpu_rdata, last_cpu);
            check_val({tag, "/ldr_rdata_hold"}, ldr_rdata, last_ldr);
        end
        check_val({tag, "/cpu_gnt"}, cpu_gnt, e_cg);
        check_val({tag, "/ldr_gnt"}, ldr_gnt, e_lg);
        check_val({tag, "/locked"}, locked, e_lk);
        if (e_lg) begin
            ea = ldr_address; ed = ldr_data; ec = {ldr_writeMode, ldr_readMode, ldr_unsignedLoad};
        end else if (e_cg) begin
            ea = cpu_address; ed = cpu_data; ec = {cpu_writeMode, cpu_readMode, cpu_unsignedLoad};
        end else begin
            ea = 32'd0; ed = 32'd0; ec = 7'd0;
        end
        check_val({tag, "/mem_address"}, mem_address, ea);
        check_val({tag, "/mem_data"}, mem_data, ed);
        check_val({tag, "/mem_cmd"}, {25'd0, mem_writeMode, mem_readMode, mem_unsignedLoad},
                  {25'd0, ec});
        is_rd = (e_cg || e_lg) && (ec[3:1] != 3'd0) && (ec[6:4] == 3'd0);
        if (is_rd) exp_q.push_back('{owner: e_lg, data: rdat});
        $display("step %-12s cpu_gnt=%0b ldr_gnt=%0b locked=%0b read=%0b", tag, cpu_gnt, ldr_gnt,
                 locked, is_rd);
        @(posedge clk);
        #1;
        mem_dataOutput = rdat;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "/cpu_rvalid"}, cpu_rvalid, 0);
        check_val({tag, "/ldr_rvalid"}, ldr_rvalid, 0);
        check_val({tag, "/cpu_rdata"}, cpu_rdata, 0);
        check_val({tag, "/ldr_rdata"}, ldr_rdata, 0);
        check_val({tag, "/locked"}, locked, 0);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs(tag);
        $display("reset %s", tag);
        exp_q.delete();
        last_cpu = 32'd0;
        last_ldr = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_cpu(0, 0, 0, 0, 0, 0);
        set_ldr(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        mem_dataOutput = 32'd0;
        set_cpu(0, 0, 0, 0, 0, 0);
        set_ldr(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_reset_outputs("init_rst");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic CPU word read with its data one cycle later.
        set_cpu(1, 32'h10, 0, 3'd0, 3'd3, 0);
        step("cpu_rd", 1, 0, 0, 32'hDEADBEEF);
        set_cpu(0, 0, 0, 0, 0, 0);
        step("cpu_rd_rsp", 0, 0, 0, $urandom);

        // Byte write, then an idle cycle with the port parked.
        set_cpu(1, 32'h21, 32'hAB, 3'd1, 3'd0, 0);
        step("cpu_wr_b", 1, 0, 0, $urandom);
        set_cpu(0, 0, 0, 0, 0, 0);
        step("idle", 0, 0, 0, $urandom);

        // Both modes set counts as a write; both NONE is granted silently.
        set_cpu(1, 32'h30, 32'h1234, 3'd3, 3'd3, 1);
        step("cpu_rdwr", 1, 0, 0, $urandom);
        set_cpu(1, 32'h34, 32'h5678, 3'd0, 3'd0, 0);
        step("cpu_none", 1, 0, 0, $urandom);

        // Alternating owners, back-to-back reads.
        set_cpu(1, 32'h4, 0, 3'd0, 3'd3, 1);
        step("alt_cpu", 1, 0, 0, 32'h11112222);
        set_cpu(0, 0, 0, 0, 0, 0);
        set_ldr(1, 0, 32'h8, 0, 3'd0, 3'd2, 0);
        step("alt_ldr", 0, 1, 0, 32'h33334444);
        set_ldr(0, 0, 0, 0, 0, 0, 0);
        step("alt_rsp", 0, 0, 0, $urandom);
        step("alt_idle", 0, 0, 0, $urandom);

        // Both requesters held: loader forced through after eight losses when guarded.
        set_cpu(1, 32'h40, 0, 3'd0, 3'd3, 0);
        set_ldr(1, 0, 32'h80, 0, 3'd0, 3'd3, 0);
        for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            step($sformatf("starve%0d", i), i != 8, i == 8, 0, $urandom);
`else
            step($sformatf("starve%0d", i), 1, 0, 0, $urandom);
`endif
        end
        set_cpu(0, 0, 0, 0, 0, 0);
        set_ldr(0, 0, 0, 0, 0, 0, 0);
        step("starve_end", 0, 0, 0, $urandom);

        // Lock without a request does nothing.
        set_ldr(0, 1, 0, 0, 0, 0, 0);
        step("lock_noreq", 0, 0, 0, $urandom);
        set_ldr(0, 0, 0, 0, 0, 0, 0);
        step("lock_noreq2", 0, 0, 0, $urandom);

        // Locked burst: CPU shut out until the lock drops.
        set_ldr(1, 1, 32'h100, 0, 3'd0, 3'd3, 0);
        step("lock_gnt", 0, 1, 0, $urandom);
        set_cpu(1, 32'h200, 0, 3'd0, 3'd3, 0);
        for (int i = 0; i < 4; i++) begin
            set_ldr(1, 1, 32'h104 + 32'(4 * i), 0, 3'd0, 3'd3, 0);
            step($sformatf("locked%0d", i), 0, 1, 1, $urandom);
        end
        set_ldr(0, 1, 0, 0, 0, 0, 0);
        step("lock_noreq_l", 0, 0, 1, $urandom);
        set_ldr(1, 0, 32'h120, 32'hCAFE, 3'd3, 3'd0, 0);
        step("unlock", 0, 1, 1, $urandom);
        set_ldr(0, 0, 0, 0, 0, 0, 0);
        step("cpu_after", 1, 0, 0, $urandom);
        set_cpu(0, 0, 0, 0, 0, 0);
        step("cpu_after_rsp", 0, 0, 0, $urandom);

        // Reset during a locked read burst, with a CPU read offered in the reset cycle.
        set_ldr(1, 1, 32'h300, 0, 3'd0, 3'd3, 0);
        step("rst_lock", 0, 1, 0, $urandom);
        step("rst_lock_rd", 0, 1, 1, $urandom);
        set_cpu(1, 32'h44, 0, 3'd0, 3'd3, 0);
        apply_reset("mid_rst");
        set_cpu(1, 32'h48, 0, 3'd0, 3'd3, 0);
        set_ldr(1, 1, 32'h304, 0, 3'd0, 3'd3, 0);
        step("post_rst", 1, 0, 0, 32'h55667788);
        set_cpu(0, 0, 0, 0, 0, 0);
        set_ldr(0, 0, 0, 0, 0, 0, 0);
        step("post_rst_rsp", 0, 0, 0, $urandom);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the Memory block's single data port (port a: address, data, readMode/writeMode, unsignedLoad, dataOutput) between the CPU load/store stage and the program loader/debug requester. It grants one requester per cycle, muxes that requester's command onto the Memory port, and routes the one-cycle-late read data back to the owner. Loader bursts can lock the port. The PC fetch port (port b) is untouched.

## Interface
Parameters:
- STARVE_LIMIT, 8: consecutive denied loader-request cycles before the loader is forced ahead of the CPU (range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU command valid; command held stable until cpu_gnt
- cpu_address  in  32  byte address
- cpu_data  in  32  write data
- cpu_writeMode / cpu_readMode  in  3  ReadWriteModes encoding (NONE=0, BYTE=1, HALFWORD=2, WORD=3, WORDLEFT=4, WORDRIGHT=5)
- cpu_unsignedLoad  in  1  zero-extend loads
- cpu_gnt  out  1  command issued to Memory this cycle
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  32  read data
- ldr_req, ldr_address, ldr_data, ldr_writeMode, ldr_readMode, ldr_unsignedLoad, ldr_gnt, ldr_rvalid, ldr_rdata: same as cpu_* for the loader
- ldr_lock  in  1  loader requests exclusive ownership
- mem_address  out  32, mem_data  out  32, mem_writeMode  out  3, mem_readMode  out  3, mem_unsignedLoad  out  1: drive Memory port a
- mem_dataOutput  in  32  Memory dataOutput, valid the cycle after a read is issued
- locked  out  1  high while in state LOCKED

## Operation
- Grant is combinational from req inputs plus registered state/counter; at most one gnt per cycle.
- No grant: mem_writeMode = mem_readMode = NONE, mem_address/mem_data/mem_unsignedLoad = 0.
- Grant: winner's five command fields pass straight to mem_*.
- FSM states: IDLE, LOCKED.
- IDLE priority:
  - ldr_req and starve_cnt == STARVE_LIMIT -> loader
  - else cpu_req -> CPU
  - else ldr_req -> loader
- IDLE -> LOCKED when the loader is granted with ldr_lock=1.
- LOCKED: cpu_gnt forced 0; ldr_gnt = ldr_req. LOCKED -> IDLE on the first cycle with ldr_lock=0; ldr_req in that cycle is still granted to the loader.
- ldr_lock without ldr_req in IDLE is ignored.
- starve_cnt (4 bits):
  - increments when ldr_req=1 and ldr_gnt=0, saturating at STARVE_LIMIT
  - clears on ldr_gnt or ldr_req=0
- Read tracking: registered tag {rd_pending, rd_owner} set when the granted command has readMode!=NONE and writeMode==NONE.
- Next cycle: owner_rvalid=1, owner_rdata = mem_dataOutput; the other rdata holds its last value.
- Writes and commands with both modes NONE are granted but produce no rvalid.
- Both modes non-NONE counts as a write (Memory gives write precedence): no rvalid.
- Back-to-back reads, including alternating owners, each give exactly one rvalid one cycle after their gnt.

## Timing
- Grant latency: 0 cycles (gnt in the cycle req is seen, if won). Read data latency: 1 cycle after gnt.
- Throughput: one access per cycle.
- Reset (rst=0 at an edge): state IDLE, starve_cnt=0, rd_pending=0.
- Outputs during and after reset: cpu_rvalid=ldr_rvalid=0, cpu_rdata=ldr_rdata=0, locked=0; gnts follow IDLE rules from the first cycle after reset.
- Reset mid-operation: a read issued in the cycle reset is sampled produces no rvalid; lock is released.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: starve_cnt and forced-loader rule present as above.
- Not defined: starve_cnt removed; strict CPU priority in IDLE; STARVE_LIMIT unused.

## Test plan
- Reset then cpu_req WORD read @0x10, mem_dataOutput=0xDEADBEEF next cycle -> cpu_gnt same cycle, cpu_rvalid=1 with cpu_rdata=0xDEADBEEF one cycle later, ldr_rvalid=0.
- cpu_req and ldr_req held continuously, STARVE_LIMIT=8 -> cpu wins 8 cycles, ldr_gnt on cycle 9, counter clears, cpu wins again; with macro undefined, ldr_gnt never asserts.
- Loader granted with ldr_lock=1 for 4 cycles while cpu_req=1 -> locked=1, cpu_gnt=0 throughout; ldr_lock drops -> that cycle ldr_gnt, next cycle cpu_gnt=1, locked=0.
- Alternating CPU read @0x4 then loader read @0x8 in consecutive cycles -> cpu_rvalid then ldr_rvalid in the next two cycles, each carrying its own mem_dataOutput.
- CPU BYTE write @0x21 data 0xAB -> mem_writeMode=1, mem_address=0x21, mem_data=0xAB, no rvalid; no request -> mem modes NONE.
- rst=0 in the cycle after a read grant -> no rvalid; locked=0, all rdata=0.
